mem_bus_mux: RTL and testbench

Parametrised successor to the two-way memory selector. It routes one core memory port to N_CH memory-mapped targets: data RAM, GPU video RAM, IO latch and later targets. Each target has its own fixed read latency. The block has a request/ready handshake, so the core can stall on slow targets. It sits between core and the RAM, GPU and IO instances in the top level.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_bus_lat_cnt.sv | 47 ++++
 rtl/mem_bus_mux.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_bus_mux.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the memory bus selector (mem_bus_mux):
//   state_e : access sequencer states, 2-bit encoding
//   LAT_W   : width of one per-channel read latency field
//   STAT_W  : width of one per-channel completed-access counter
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int LAT_W  = 3;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage : mem_bus_pkg

// File: rtl/mem_bus_lat_cnt.sv
// -----------------------------------------------------------------------------
// mem_bus_lat_cnt
// Loadable down-counter that times the read latency of the selected target.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; holds at zero
//   cnt        : current count
//   zero       : count is zero
// -----------------------------------------------------------------------------
module mem_bus_lat_cnt
    import mem_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic [LAT_W-1:0] cnt,
    output logic             zero
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule : mem_bus_lat_cnt

// File: rtl/mem_bus_mux.sv
// -----------------------------------------------------------------------------
// mem_bus_mux
// Routes one core memory port to N_CH memory-mapped targets, each with its own
// fixed read latency, behind a request/ready handshake.
//
// Ports:
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   REQ        : access request, sampled only in IDLE
//   WREN       : 1 = write, 0 = read
//   SELECT     : target index; SELECT >= N_CH completes with ERR
//   ADDR, DATA : address and write data, captured with REQ
//   READY      : one-cycle completion pulse
//   Q          : read data, valid with READY on a read
//   ERR        : one-cycle pulse with READY for an out-of-range SELECT
//   CH_REQ     : one-hot one-cycle strobe to the selected target
//   CH_WREN    : one-hot write enable, high only with the strobe
//   CH_ADDR    : captured address, broadcast to all targets
//   CH_DATA    : captured write data, broadcast to all targets
//   CH_Q       : target read data, channel k at [k*DATA_W +: DATA_W]
//   STATS      : (MEM_BUS_STATS_EN only) per-channel completed-access
//                counters, channel k at [k*16 +: 16]
//
// Optional feature macro: MEM_BUS_STATS_EN
// -----------------------------------------------------------------------------
module mem_bus_mux
    import mem_bus_pkg::*;
#(
    parameter int                    DATA_W = 16,
    parameter int                    ADDR_W = 12,
    parameter int                    N_CH   = 4,
    parameter int                    SEL_W  = 3,
    parameter logic [N_CH*LAT_W-1:0] CH_LAT = {N_CH{3'd1}}
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   REQ,
    input  logic                   WREN,
    input  logic [SEL_W-1:0]       SELECT,
    input  logic [ADDR_W-1:0]      ADDR,
    input  logic [DATA_W-1:0]      DATA,
    output logic                   READY,
    output logic [DATA_W-1:0]      Q,
    output logic                   ERR,
    output logic [N_CH-1:0]        CH_REQ,
    output logic [N_CH-1:0]        CH_WREN,
    output logic [ADDR_W-1:0]      CH_ADDR,
    output logic [DATA_W-1:0]      CH_DATA,
    input  logic [N_CH*DATA_W-1:0] CH_Q
`ifdef MEM_BUS_STATS_EN
    ,
    output logic [N_CH*STAT_W-1:0] STATS
`endif
);

    state_e              state_q,   state_d;
    logic [SEL_W-1:0]    sel_q,     sel_d;
    logic                wren_q,    wren_d;
    logic                bad_q,     bad_d;
    logic [ADDR_W-1:0]   ch_addr_q, ch_addr_d;
    logic [DATA_W-1:0]   ch_data_q, ch_data_d;
    logic [N_CH-1:0]     ch_req_q,  ch_req_d;
    logic [N_CH-1:0]     ch_wren_q, ch_wren_d;
    logic                ready_q,   ready_d;
    logic                err_q,     err_d;
    logic [DATA_W-1:0]   q_q,       q_d;

    logic [N_CH-1:0]     sel_hot;
    logic                sel_bad;
    logic [LAT_W-1:0]    lat_sel;
    logic [DATA_W-1:0]   ch_q_sel;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;
    logic [LAT_W-1:0]    cnt_val;

`ifdef MEM_BUS_STATS_EN
    logic [N_CH-1:0][STAT_W-1:0] stats_q, stats_d;
`endif

    // Decode of the live SELECT (used only at capture time).
    assign sel_bad = (32'(SELECT) >= N_CH);

    always_comb begin
        sel_hot = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (SELECT == SEL_W'(k)) begin
                sel_hot[k] = 1'b1;
            end
        end
    end

    // Latency and read data of the captured channel.
    always_comb begin
        lat_sel  = '0;
        ch_q_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_q == SEL_W'(k)) begin
                lat_sel  = CH_LAT[k*LAT_W +: LAT_W];
                ch_q_sel = CH_Q[k*DATA_W +: DATA_W];
            end
        end
    end

    mem_bus_lat_cnt u_lat_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (cnt_load),
        .load_val (lat_sel - LAT_W'(1)),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wren_d    = wren_q;
        bad_d     = bad_q;
        ch_addr_d = ch_addr_q;
        ch_data_d = ch_data_q;
        ch_req_d  = '0;
        ch_wren_d = '0;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        q_d       = q_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (REQ) begin
                    sel_d   = SELECT;
                    wren_d  = WREN;
                    bad_d   = sel_bad;
                    state_d = ACCESS;
                    // An out-of-range select still passes through ACCESS so
                    // that it completes with the same timing as a write, but
                    // it never touches the target side.
                    if (!sel_bad) begin
                        ch_addr_d = ADDR;
                        ch_data_d = DATA;
                        ch_req_d  = sel_hot;
                        ch_wren_d = WREN ? sel_hot : '0;
                    end
                end
            end

            ACCESS: begin
                if (bad_q) begin
                    q_d     = '0;
                    state_d = DONE;
                end else if (wren_q) begin
                    state_d = DONE;
                end else begin
                    // Every read visits WAIT: data is latched on the edge
                    // CH_LAT cycles after the strobe cycle ends.
                    cnt_load = 1'b1;
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                if (cnt_zero) begin
                    q_d     = ch_q_sel;
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            DONE: begin
                ready_d = 1'b1;
                err_d   = bad_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_BUS_STATS_EN
    // Counters advance together with READY; the adder wraps FFFF -> 0.
    always_comb begin
        stats_d = stats_q;
        if ((state_q == DONE) && !bad_q) begin
            for (int k = 0; k < N_CH; k++) begin
                if (sel_q == SEL_W'(k)) begin
                    stats_d[k] = stats_q[k] + STAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stats_q <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign STATS = stats_q;
`endif

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    // NOTE: every flop, including captured data, is asynchronously reset so
    // an abandoned access leaves no residue on the outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            wren_q    <= 1'b0;
            bad_q     <= 1'b0;
            ch_addr_q <= '0;
            ch_data_q <= '0;
            ch_req_q  <= '0;
            ch_wren_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wren_q    <= wren_d;
            bad_q     <= bad_d;
            ch_addr_q <= ch_addr_d;
            ch_data_q <= ch_data_d;
            ch_req_q  <= ch_req_d;
            ch_wren_q <= ch_wren_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            q_q       <= q_d;
        end
    end

    assign READY   = ready_q;
    assign ERR     = err_q;
    assign Q       = q_q;
    assign CH_REQ  = ch_req_q;
    assign CH_WREN = ch_wren_q;
    assign CH_ADDR = ch_addr_q;
    assign CH_DATA = ch_data_q;

endmodule : mem_bus_mux

// File: tb/tb_mem_bus_mux.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_mux
// Scoreboard bench for mem_bus_mux. Channel latencies: ch0=1, ch1=3, ch2=1,
// ch3=7. Stimulus pushes the expected completion (cycle, Q, ERR) into a queue;
// a monitor pops and compares whenever READY is seen.
// -----------------------------------------------------------------------------
module tb_mem_bus_mux;

    localparam logic [11:0] TB_LAT = {3'd7, 3'd1, 3'd3, 3'd1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wren = 1'b0;
    logic [2:0]  sel = '0;
    logic [11:0] addr = '0;
    logic [15:0] data = '0;
    logic        ready;
    logic [15:0] q;
    logic        err;
    logic [3:0]  ch_req;
    logic [3:0]  ch_wren;
    logic [11:0] ch_addr;
    logic [15:0] ch_data;
    logic [63:0] ch_q = '0;
`ifdef MEM_BUS_STATS_EN
    logic [63:0] stats;
`endif

    mem_bus_mux #(
        .DATA_W (16),
        .ADDR_W (12),
        .N_CH   (4),
        .SEL_W  (3),
        .CH_LAT (TB_LAT)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .REQ     (req),
        .WREN    (wren),
        .SELECT  (sel),
        .ADDR    (addr),
        .DATA    (data),
        .READY   (ready),
        .Q       (q),
        .ERR     (err),
        .CH_REQ  (ch_req),
        .CH_WREN (ch_wren),
        .CH_ADDR (ch_addr),
        .CH_DATA (ch_data),
        .CH_Q    (ch_q)
`ifdef MEM_BUS_STATS_EN
        ,
        .STATS   (stats)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cyc;
        logic [15:0] q;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every READY must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", {31'd0, ready}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_ready_cycle"}, cyc, e.cyc);
                check({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
                check({e.name, "_q"}, {16'd0, q}, {16'd0, e.q});
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_seen"}, {31'd0, ready}, 32'd1);
    endtask

    // One access: drive for one cycle, scramble the inputs afterwards (they
    // must be ignored), check the strobe cycle, then wait for completion.
    task automatic access(input logic [2:0] s, input logic wr, input logic [11:0] a,
                          input logic [15:0] d, input int lat, input logic [15:0] exp_q,
                          input logic exp_err, input string name);
        exp_t       e;
        logic [3:0] hot;
        @(negedge clk);
        req = 1'b1; wren = wr; sel = s; addr = a; data = d;
        e.cyc = cyc + 1 + lat; e.q = exp_q; e.err = exp_err; e.name = name;
        sb.push_back(e);
        hot = exp_err ? 4'b0000 : (4'b0001 << s);
        @(negedge clk);
        req = 1'b0; wren = ~wr; sel = ~s; addr = ~a; data = ~d;
        check({name, "_ch_req"}, {28'd0, ch_req}, {28'd0, hot});
        check({name, "_ch_wren"}, {28'd0, ch_wren}, {28'd0, (wr ? hot : 4'b0000)});
        if (!exp_err) begin
            check({name, "_ch_addr"}, {20'd0, ch_addr}, {20'd0, a});
            check({name, "_ch_data"}, {16'd0, ch_data}, {16'd0, d});
        end
        @(negedge clk);
        check({name, "_ch_req_off"}, {24'd0, ch_req, ch_wren}, 32'd0);
        wait_ready(name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, {31'd0, ready}, 32'd0);
        check({name, "_err"}, {31'd0, err}, 32'd0);
        check({name, "_ch_req_wren"}, {24'd0, ch_req, ch_wren}, 32'd0);
        check({name, "_q"}, {16'd0, q}, 32'd0);
        check({name, "_ch_addr_data"}, {4'd0, ch_addr, ch_data}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        int readies;
        int a0;

        // Reset state.
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Write ch0; Q untouched (still reset value).
        access(3'd0, 1'b1, 12'h010, 16'hBEEF, 2, 16'h0000, 1'b0, "wr_ch0");

        // Read ch1 (latency 3); later change of CH_Q[1] must not alter Q.
        ch_q[16 +: 16] = 16'h1234;
        access(3'd1, 1'b0, 12'h020, 16'h0000, 5, 16'h1234, 1'b0, "rd_ch1");
        ch_q[16 +: 16] = 16'hFFFF;
        @(negedge clk);
        check("rd_ch1_q_hold", {16'd0, q}, 32'h0000_1234);

        // Read ch0 (latency 1).
        ch_q[0 +: 16] = 16'hA5A5;
        access(3'd0, 1'b0, 12'h100, 16'h0000, 3, 16'hA5A5, 1'b0, "rd_ch0");

        // Write ch3 at top address; Q keeps last read data.
        access(3'd3, 1'b1, 12'hFFF, 16'h0001, 2, 16'hA5A5, 1'b0, "wr_ch3");

        // Read ch3 (maximum latency 7).
        ch_q[48 +: 16] = 16'h0F0F;
        access(3'd3, 1'b0, 12'h7FF, 16'h0000, 9, 16'h0F0F, 1'b0, "rd_ch3");

        // Out-of-range selects: ERR with READY, Q cleared, no strobes.
        access(3'd5, 1'b0, 12'h055, 16'h0000, 2, 16'h0000, 1'b1, "err_sel5");
        access(3'd7, 1'b1, 12'h077, 16'h7777, 2, 16'h0000, 1'b1, "err_sel7");
        check("err_ch_addr_kept", {20'd0, ch_addr}, 32'h0000_07FF);

        // Read ch2 (latency 1).
        ch_q[32 +: 16] = 16'hC3C3;
        access(3'd2, 1'b0, 12'h0C3, 16'h0000, 3, 16'hC3C3, 1'b0, "rd_ch2");

        // REQ held high: writes accepted every 3 cycles, never mid-access.
        @(negedge clk);
        req = 1'b1; wren = 1'b1; sel = 3'd2; addr = 12'h0AB; data = 16'h1111;
        a0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.cyc = a0 + 2 + 3 * i; e.q = 16'hC3C3; e.err = 1'b0; e.name = "b2b";
            sb.push_back(e);
        end
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ch_req[2]) strobes++;
            if (cyc == a0 + 6) req = 1'b0;
        end
        check("b2b_strobes", strobes, 3);
        check("b2b_all_done", sb.size(), 0);

        // Reset asserted while a ch3 read is in WAIT.
        @(negedge clk);
        req = 1'b1; wren = 1'b0; sel = 3'd3; addr = 12'h333;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        readies = 0;
        repeat (12) begin
            @(negedge clk);
            if (ready) readies++;
        end
        check("midrst_no_ready", readies, 0);

`ifdef MEM_BUS_STATS_EN
        // Counters restart from zero after the reset above.
        access(3'd2, 1'b0, 12'h001, 16'h0000, 3, 16'hC3C3, 1'b0, "st_rd0");
        access(3'd2, 1'b0, 12'h002, 16'h0000, 3, 16'hC3C3, 1'b0, "st_rd1");
        access(3'd2, 1'b0, 12'h003, 16'h0000, 3, 16'hC3C3, 1'b0, "st_rd2");
        access(3'd4, 1'b0, 12'h004, 16'h0000, 2, 16'h0000, 1'b1, "st_err");
        @(negedge clk);
        check("stats_ch0", {16'd0, stats[0 +: 16]}, 32'd0);
        check("stats_ch1", {16'd0, stats[16 +: 16]}, 32'd0);
        check("stats_ch2", {16'd0, stats[32 +: 16]}, 32'd3);
        check("stats_ch3", {16'd0, stats[48 +: 16]}, 32'd0);
`endif

        // Normal access after reset release.
        ch_q[16 +: 16] = 16'h5678;
        access(3'd1, 1'b0, 12'h0AA, 16'h0000, 5, 16'h5678, 1'b0, "post_rst_rd");

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mem_bus_mux
